// File: rtl/dram_arbiter_if.sv
// Signal bundle between dram_arbiter, its requesters and the DRAM port.
// Latency: none (wires only).
// Backpressure: none here; master = arbiter view, slave = requester/DRAM environment view.
interface dram_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            req_rdwr;
  logic [NUM_REQ-1:0][7:0]       req_en;
  logic [NUM_REQ-1:0][7:0][63:0] req_addr;
  logic [NUM_REQ-1:0][7:0][7:0]  req_data;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [7:0][7:0]               rsp_data;
  logic                          rsp_err;
  logic [7:0]                    dram_en;
  logic                          dram_rdwr;
  logic [7:0][63:0]              dram_addr;
  logic [7:0][7:0]               dram_data_in;
  logic [7:0][7:0]               dram_data_out;
  logic [7:0]                    dram_valid;

  modport master (
    input  req_valid, req_rdwr, req_en, req_addr, req_data, dram_data_out, dram_valid,
    output req_ready, rsp_valid, rsp_data, rsp_err, dram_en, dram_rdwr, dram_addr, dram_data_in
  );

  modport slave (
    output req_valid, req_rdwr, req_en, req_addr, req_data, dram_data_out, dram_valid,
    input  req_ready, rsp_valid, rsp_data, rsp_err, dram_en, dram_rdwr, dram_addr, dram_data_in
  );
endinterface

// File: rtl/dram_arbiter.sv
// Round-robin arbiter sharing one 8-lane DRAM command port among NUM_REQ requesters; macro DRAM_ARB_TIMEOUT_EN adds a read watchdog.
// Latency: grant in IDLE, DRAM issue next cycle; write rsp at issue+WR_LATENCY+1, read rsp the cycle after dram_valid.
// Backpressure: single outstanding transaction; req_ready pulses only in IDLE, so requesters hold req_valid until granted.
module dram_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int WR_LATENCY = 24,
  parameter int TIMEOUT    = 64
) (
  input  logic           clk,
  input  logic           reset,
  dram_arbiter_if.master bus
);
  localparam int         IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [7:0] WR_LAST = 8'(WR_LATENCY - 1);
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_RD, WAIT_WR, RESP} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   owner;
  logic [IDW-1:0]   grant_idx;
  logic [IDW-1:0]   c_idx;
  logic             grant_any;
  int               cand;
  logic [7:0]       lat_en;
  logic [7:0]       cnt;
  logic             rd_hit;
  logic             dram_rdwr_q;
  logic [7:0][63:0] dram_addr_q;
  logic [7:0][7:0]  dram_data_q;
  logic [7:0][7:0]  rsp_data_q;

  assign rd_hit           = |(bus.dram_valid & lat_en);
  assign bus.dram_rdwr    = dram_rdwr_q;
  assign bus.dram_addr    = dram_addr_q;
  assign bus.dram_data_in = dram_data_q;
  assign bus.rsp_data     = rsp_data_q;

`ifdef DRAM_ARB_TIMEOUT_EN
  logic rsp_err_q;
  assign bus.rsp_err = rsp_err_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TO_LAST;
  assign bus.rsp_err    = 1'b0;
`endif

  // Round-robin pick: scan downward so the valid requester closest after rr_ptr is written last and wins
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = 0;
    c_idx     = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand  = (int'(rr_ptr) + k) % NUM_REQ;
      c_idx = IDW'(cand);
      if (bus.req_valid[c_idx]) begin
        grant_any = 1'b1;
        grant_idx = c_idx;
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state: empty-mask grants jump straight to RESP; reads wait for a masked dram_valid
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_any) state_nxt = (bus.req_en[grant_idx] == 8'h00) ? RESP : ISSUE;
      ISSUE:   state_nxt = dram_rdwr_q ? WAIT_RD : WAIT_WR;
      WAIT_RD: begin
        if (rd_hit) state_nxt = RESP;
`ifdef DRAM_ARB_TIMEOUT_EN
        else if (cnt == TO_LAST) state_nxt = RESP;
`endif
      end
      WAIT_WR: if (cnt == WR_LAST) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: one-cycle grant, DRAM enable and completion pulses, all forced low while reset is held
  always_comb begin
    bus.req_ready = '0;
    bus.rsp_valid = '0;
    bus.dram_en   = '0;
    if (!reset) begin
      case (state)
        IDLE:    if (grant_any) bus.req_ready[grant_idx] = 1'b1;
        ISSUE:   bus.dram_en = lat_en;
        RESP:    bus.rsp_valid[owner] = 1'b1;
        default: ;
      endcase
    end
  end

  // Datapath: latch the winner, run the saturating wait counter, capture read data into the response
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr      <= '0;
      owner       <= '0;
      lat_en      <= '0;
      cnt         <= '0;
      dram_rdwr_q <= 1'b0;
      dram_addr_q <= '0;
      dram_data_q <= '0;
      rsp_data_q  <= '0;
`ifdef DRAM_ARB_TIMEOUT_EN
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            owner      <= grant_idx;
            rr_ptr     <= (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
            lat_en     <= bus.req_en[grant_idx];
            rsp_data_q <= '0;
`ifdef DRAM_ARB_TIMEOUT_EN
            rsp_err_q  <= 1'b0;
`endif
            // DRAM command outputs only change for a real issue so they hold between issues
            if (bus.req_en[grant_idx] != 8'h00) begin
              dram_rdwr_q <= bus.req_rdwr[grant_idx];
              dram_addr_q <= bus.req_addr[grant_idx];
              dram_data_q <= bus.req_data[grant_idx];
            end
          end
        end
        ISSUE: cnt <= '0;
        WAIT_RD: begin
          if (cnt != 8'hFF) cnt <= cnt + 8'd1;
          if (rd_hit) begin
            for (int l = 0; l < 8; l++) rsp_data_q[l] <= lat_en[l] ? bus.dram_data_out[l] : 8'h00;
          end
`ifdef DRAM_ARB_TIMEOUT_EN
          else if (cnt == TO_LAST) rsp_err_q <= 1'b1;
`endif
        end
        WAIT_WR: if (cnt != 8'hFF) cnt <= cnt + 8'd1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_dram_arbiter.sv
// Bench for dram_arbiter: directed scenarios followed by randomized transactions against a transaction-level model.
// Latency: checks exact grant, issue and response cycles.
// Backpressure: requesters hold req_valid until their grant pulse.
module tb_dram_arbiter;
  localparam int NR  = 4;
  localparam int WRL = 24;
  localparam int TMO = 64;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dram_arbiter_if #(.NUM_REQ(NR)) rif();

  dram_arbiter #(.NUM_REQ(NR), .WR_LATENCY(WRL), .TIMEOUT(TMO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (rif.master)
  );

  int checks = 0;
  int errors = 0;
  int en_pulses = 0;
  int rsp_pulses = 0;
  int grants = 0;
  int multi_hot = 0;
  int exp_en = 0;

  // Passive monitor of pulse counts outside reset
  always @(negedge clk) begin
    if (!reset) begin
      if (rif.dram_en != 8'h00) en_pulses++;
      if (rif.rsp_valid != '0) rsp_pulses++;
      if (rif.req_ready != '0) grants++;
      if (!$onehot0(rif.req_ready) || !$onehot0(rif.rsp_valid)) multi_hot++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NR-1:0] oh(input int i);
    return NR'(1) << i;
  endfunction

  function automatic logic [7:0] mem_byte(input logic [63:0] a);
    return a[7:0] * 8'd13 + 8'h5A;
  endfunction

  task automatic do_reset(input int n);
    reset = 1'b1;
    rif.req_valid = '0;
    rif.dram_valid = '0;
    repeat (n) nxt();
    reset = 1'b0;
  endtask

  // Caller sits just after a posedge; checks the current cycle first
  task automatic wait_grant(input int budget, output logic [NR-1:0] g, output int waited);
    waited = 0;
    mid();
    g = rif.req_ready;
    while (g == '0 && waited < budget) begin
      nxt(); mid(); waited++;
      g = rif.req_ready;
    end
  endtask

  // Caller sits at a negedge; counts cycles until rsp_valid
  task automatic wait_rsp(input int budget, output int waited, output bit seen);
    seen = 1'b0;
    waited = 0;
    while (!seen && waited < budget) begin
      nxt(); mid(); waited++;
      if (rif.rsp_valid != '0) seen = 1'b1;
    end
  endtask

  initial begin
    logic [NR-1:0]            g, vmask, p_rdwr;
    logic [NR-1:0][7:0]       p_en;
    logic [NR-1:0][7:0][63:0] p_addr;
    logic [NR-1:0][7:0][7:0]  p_data;
    logic [7:0][7:0]          exp_d, rnd_d;
    logic [7:0][63:0]         addr_v;
    logic [7:0]               vv;
    int waited, w, rr, d, early, quiet, g0, r0;
    bit seen;

    reset = 1'b1;
    rif.req_valid = '1;
    rif.req_rdwr = '0;
    rif.req_en = '0;
    rif.req_addr = '0;
    rif.req_data = '0;
    rif.dram_valid = '0;
    rif.dram_data_out = '0;
    repeat (3) nxt();
    mid();
    chk("reset_req_ready", rif.req_ready, '0);
    chk("reset_rsp_valid", rif.rsp_valid, '0);
    chk("reset_dram_en", rif.dram_en, '0);
    chk("reset_rsp_data", rif.rsp_data, '0);
    chk("reset_rsp_err", rif.rsp_err, 1'b0);
    nxt();
    rif.req_valid = '0;
    reset = 1'b0;

    // Requester 1 read, two lanes, DRAM answers 22 cycles after issue
    addr_v = '0;
    addr_v[0] = 64'd5;
    addr_v[1] = 64'd6;
    rif.req_valid = 4'b0010;
    rif.req_rdwr[1] = 1'b1;
    rif.req_en[1] = 8'h03;
    rif.req_addr[1] = addr_v;
    rif.req_data[1] = {$urandom, $urandom};
    mid();
    chk("r33_grant", rif.req_ready, 4'b0010);
    nxt();
    rif.req_valid = '0;
    mid();
    chk("r33_dram_en", rif.dram_en, 8'h03);
    chk("r33_dram_rdwr", rif.dram_rdwr, 1'b1);
    chk("r33_dram_addr", rif.dram_addr, addr_v);
    exp_en++;
    quiet = 0;
    for (int j = 1; j < 22; j++) begin
      nxt();
      rif.dram_valid = 8'hFC;
      mid();
      if (rif.dram_en != 8'h00 || rif.rsp_valid != '0) quiet++;
    end
    nxt();
    rnd_d = {$urandom, $urandom};
    rnd_d[0] = mem_byte(64'd5);
    rnd_d[1] = mem_byte(64'd6);
    rif.dram_valid = 8'hF3;
    rif.dram_data_out = rnd_d;
    exp_d = '0;
    exp_d[0] = mem_byte(64'd5);
    exp_d[1] = mem_byte(64'd6);
    mid();
    chk("r33_quiet_wait", quiet, 0);
    chk("r33_no_early_rsp", rif.rsp_valid, '0);
    nxt();
    rif.dram_valid = '0;
    rif.dram_data_out = {$urandom, $urandom};
    mid();
    chk("r33_rsp_valid", rif.rsp_valid, 4'b0010);
    chk("r33_rsp_data", rif.rsp_data, exp_d);
    chk("r33_rsp_err", rif.rsp_err, 1'b0);
    nxt(); mid();
    chk("r33_rsp_one_cycle", rif.rsp_valid, '0);

    // All four requesters write at once after reset
    nxt();
    do_reset(2);
    for (int i = 0; i < NR; i++) begin
      p_rdwr[i] = 1'b0;
      p_en[i] = 8'hFF;
      for (int l = 0; l < 8; l++) p_addr[i][l] = {$urandom, $urandom};
      p_data[i] = {$urandom, $urandom};
    end
    rif.req_rdwr = p_rdwr;
    rif.req_en = p_en;
    rif.req_addr = p_addr;
    rif.req_data = p_data;
    rif.req_valid = 4'b1111;
    for (int k = 0; k < NR; k++) begin
      wait_grant(60, g, waited);
      chk("r34_grant_order", g, oh(k));
      nxt();
      rif.req_valid[k] = 1'b0;
      mid();
      chk("r34_issue_en", rif.dram_en, 8'hFF);
      chk("r34_issue_rdwr", rif.dram_rdwr, 1'b0);
      chk("r34_issue_addr", rif.dram_addr, p_addr[k]);
      chk("r34_issue_data", rif.dram_data_in, p_data[k]);
      exp_en++;
      wait_rsp(WRL + 10, waited, seen);
      chk("r34_wr_latency", waited, WRL + 1);
      chk("r34_rsp_owner", rif.rsp_valid, oh(k));
      nxt();
    end

    // Empty-mask request from 2, then no grant during RESP, then turnaround grant to 0
    rif.req_en = '0;
    rif.req_rdwr[2] = 1'b1;
    rif.req_valid = 4'b0100;
    mid();
    chk("r35_grant", rif.req_ready, 4'b0100);
    nxt();
    rif.req_valid = 4'b0001;
    mid();
    chk("r35_rsp_valid", rif.rsp_valid, 4'b0100);
    chk("r35_rsp_data", rif.rsp_data, '0);
    chk("r35_rsp_err", rif.rsp_err, 1'b0);
    chk("r35_no_dram_en", rif.dram_en, '0);
    chk("r35_no_grant_in_resp", rif.req_ready, '0);
    nxt(); mid();
    chk("r35_turnaround_grant", rif.req_ready, 4'b0001);
    nxt();
    rif.req_valid = '0;
    mid();
    chk("r35_rsp0", rif.rsp_valid, 4'b0001);
    nxt();
    chk("r35_en_pulse_count", en_pulses, exp_en);

    // Read from 3 that the DRAM never answers on its lane
    rif.req_rdwr[3] = 1'b1;
    rif.req_en[3] = 8'h01;
    rif.req_addr[3] = {8{$urandom, $urandom}};
    rif.req_valid = 4'b1000;
    mid();
    chk("r36_grant", rif.req_ready, 4'b1000);
    nxt();
    rif.req_valid = 4'b0001;
    rif.dram_valid = 8'hFE;
    mid();
    chk("r36_issue_en", rif.dram_en, 8'h01);
    exp_en++;
    g0 = grants;
`ifdef DRAM_ARB_TIMEOUT_EN
    wait_rsp(TMO + 10, waited, seen);
    chk("r36_timeout_latency", waited, TMO + 1);
    chk("r36_timeout_owner", rif.rsp_valid, 4'b1000);
    chk("r36_timeout_err", rif.rsp_err, 1'b1);
    chk("r36_timeout_data", rif.rsp_data, '0);
`else
    wait_rsp(TMO + 30, waited, seen);
    chk("r36_stall_no_rsp", seen, 1'b0);
`endif
    nxt();
    chk("r36_no_grant_while_busy", grants - g0, 0);
    rif.req_valid = '0;
    rif.dram_valid = '0;

    // Reset ten cycles into a read drops it; next grant goes to 0
    do_reset(2);
    rif.req_rdwr[2] = 1'b1;
    rif.req_en[2] = 8'hFF;
    rif.req_valid = 4'b0100;
    mid();
    chk("r37_grant", rif.req_ready, 4'b0100);
    nxt();
    rif.req_valid = '0;
    mid();
    chk("r37_issue_en", rif.dram_en, 8'hFF);
    exp_en++;
    repeat (10) nxt();
    reset = 1'b1;
    nxt(); nxt(); mid();
    chk("r37_reset_rsp_valid", rif.rsp_valid, '0);
    chk("r37_reset_dram_en", rif.dram_en, '0);
    chk("r37_reset_rsp_data", rif.rsp_data, '0);
    nxt();
    reset = 1'b0;
    rif.dram_valid = 8'hFF;
    rif.dram_data_out = {$urandom, $urandom};
    g0 = grants;
    r0 = rsp_pulses;
    repeat (8) nxt();
    rif.dram_valid = '0;
    chk("r37_no_rsp_after_reset", rsp_pulses - r0, 0);
    chk("r37_no_spurious_grant", grants - g0, 0);
    rif.req_en = '0;
    rif.req_valid = 4'b1111;
    mid();
    chk("r37_first_grant_req0", rif.req_ready, 4'b0001);
    nxt();
    rif.req_valid = '0;
    mid();
    chk("r37_rsp0", rif.rsp_valid, 4'b0001);

    // Requester 0 hogs; requester 3 asks once and must win the second arbitration
    nxt();
    do_reset(2);
    rif.req_en = '0;
    rif.req_valid = 4'b1001;
    mid();
    chk("r38_arb1", rif.req_ready, 4'b0001);
    nxt(); mid();
    nxt(); mid();
    chk("r38_arb2", rif.req_ready, 4'b1000);
    nxt();
    rif.req_valid = 4'b0001;
    mid();
    chk("r38_rsp3", rif.rsp_valid, 4'b1000);
    nxt(); mid();
    chk("r38_arb3", rif.req_ready, 4'b0001);
    nxt();
    rif.req_valid = '0;
    mid();
    nxt();

    // Randomized transactions against a round-robin transaction model
    do_reset(2);
    rr = 0;
    for (int t = 0; t < 40; t++) begin
      vmask = NR'($urandom_range(1, (1 << NR) - 1));
      for (int i = 0; i < NR; i++) begin
        p_rdwr[i] = 1'($urandom_range(0, 1));
        p_en[i] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
        for (int l = 0; l < 8; l++) p_addr[i][l] = {$urandom, $urandom};
        p_data[i] = {$urandom, $urandom};
      end
      rif.req_rdwr = p_rdwr;
      rif.req_en = p_en;
      rif.req_addr = p_addr;
      rif.req_data = p_data;
      rif.req_valid = vmask;
      w = -1;
      for (int k = 0; k < NR; k++) begin
        if (w < 0 && vmask[(rr + k) % NR]) w = (rr + k) % NR;
      end
      rr = (w + 1) % NR;
      mid();
      chk("rnd_grant", rif.req_ready, oh(w));
      nxt();
      rif.req_valid = '0;
      mid();
      if (p_en[w] == 8'h00) begin
        chk("rnd_empty_rsp", rif.rsp_valid, oh(w));
        chk("rnd_empty_data", rif.rsp_data, '0);
        chk("rnd_empty_no_en", rif.dram_en, '0);
      end else begin
        chk("rnd_issue_en", rif.dram_en, p_en[w]);
        chk("rnd_issue_rdwr", rif.dram_rdwr, p_rdwr[w]);
        chk("rnd_issue_addr", rif.dram_addr, p_addr[w]);
        exp_en++;
        if (!p_rdwr[w]) begin
          chk("rnd_issue_data", rif.dram_data_in, p_data[w]);
          wait_rsp(WRL + 10, waited, seen);
          chk("rnd_wr_latency", waited, WRL + 1);
          chk("rnd_wr_owner", rif.rsp_valid, oh(w));
        end else begin
          d = $urandom_range(1, 30);
          early = 0;
          exp_d = '0;
          for (int j = 1; j <= d; j++) begin
            nxt();
            rnd_d = {$urandom, $urandom};
            rif.dram_data_out = rnd_d;
            if (j < d) begin
              rif.dram_valid = 8'($urandom) & ~p_en[w];
            end else begin
              vv = 8'($urandom) & p_en[w];
              if (vv == 8'h00) vv = p_en[w];
              rif.dram_valid = vv | (8'($urandom) & ~p_en[w]);
              for (int l = 0; l < 8; l++) exp_d[l] = p_en[w][l] ? rnd_d[l] : 8'h00;
            end
            mid();
            if (rif.rsp_valid != '0) early++;
          end
          nxt();
          rif.dram_valid = '0;
          rif.dram_data_out = {$urandom, $urandom};
          mid();
          chk("rnd_rd_no_early_rsp", early, 0);
          chk("rnd_rd_owner", rif.rsp_valid, oh(w));
          chk("rnd_rd_data", rif.rsp_data, exp_d);
          chk("rnd_rd_err", rif.rsp_err, 1'b0);
        end
      end
      nxt();
    end

    chk("total_dram_en_pulses", en_pulses, exp_en);
    chk("onehot_outputs", multi_hot, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
